intersection_phase_scheduler: RTL

//  Sequences a two-road intersection (north-south, east-west) plus a pedestrian crossing.

---
 rtl/intersection_phase_scheduler_pkg.sv | 24 ++
 rtl/intersection_phase_scheduler_if.sv | 28 ++
 rtl/intersection_phase_scheduler_phase_timer.sv | 20 ++
 rtl/intersection_phase_scheduler.sv | 108 ++++++++++
 4 files changed

// File: rtl/intersection_phase_scheduler_pkg.sv
// Phase encoding and default timing for the intersection phase scheduler.
package intersection_phase_scheduler_pkg;

  typedef enum logic [2:0] {
    ST_ALL_RED = 3'd0,
    ST_NS_G    = 3'd1,
    ST_NS_Y    = 3'd2,
    ST_EW_G    = 3'd3,
    ST_EW_Y    = 3'd4,
    ST_WALK    = 3'd5
  } phase_e;

  localparam int GREEN_MIN_DEF = 8;
  localparam int YELLOW_T_DEF  = 3;
  localparam int ALLRED_T_DEF  = 2;
  localparam int WALK_T_DEF    = 6;
  localparam int CNT_W_DEF     = 8;

  // Entering a phase from a different one; used for the entry-qualified flag updates.
  function automatic logic enters(input phase_e cur, input phase_e nxt, input phase_e tgt);
    return (nxt == tgt) && (cur != tgt);
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Requester inputs, lamp outputs and debug state of the intersection phase scheduler.
interface intersection_phase_scheduler_if;
  import intersection_phase_scheduler_pkg::*;

  logic   car_ns;
  logic   car_ew;
  logic   ped_req;
  logic   ns_red;
  logic   ns_yellow;
  logic   ns_green;
  logic   ew_red;
  logic   ew_yellow;
  logic   ew_green;
  logic   walk;
  logic   ped_ack;
  phase_e state;

  modport master (
    output car_ns, car_ew, ped_req,
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack, state
  );

  modport slave (
    input  car_ns, car_ew, ped_req,
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green, walk, ped_ack, state
  );

endinterface

// File: rtl/intersection_phase_scheduler_phase_timer.sv
// Time-in-phase counter: sync clear on phase change, saturates at all-ones.
// Single-cycle update, no backpressure.
module intersection_phase_scheduler_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (!(&cnt)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Demand-driven NS/EW/pedestrian phase sequencer; lamps decode the state register directly.
// Requests are level/pulse inputs sampled every cycle; ped_ack is a registered one-cycle pulse.
module intersection_phase_scheduler
  import intersection_phase_scheduler_pkg::*;
#(
  parameter int GREEN_MIN = GREEN_MIN_DEF,
  parameter int YELLOW_T  = YELLOW_T_DEF,
  parameter int ALLRED_T  = ALLRED_T_DEF,
  parameter int WALK_T    = WALK_T_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic                           clk,
  input  logic                           reset,
  intersection_phase_scheduler_if.slave  bus
);

  localparam logic [CNT_W-1:0] GREEN_LAST  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] YELLOW_LAST = CNT_W'(YELLOW_T - 1);
  localparam logic [CNT_W-1:0] ALLRED_LAST = CNT_W'(ALLRED_T - 1);
  localparam logic [CNT_W-1:0] WALK_LAST   = CNT_W'(WALK_T - 1);

  phase_e           state_q, state_d;
  logic             serve_ew_q, serve_ew_d;
  logic             from_walk_q, from_walk_d;
  logic             ped_pending_q;
  logic             ped_ack_q;
  logic [CNT_W-1:0] timer;
  logic             phase_chg;

  assign phase_chg = (state_d != state_q);

  intersection_phase_scheduler_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (phase_chg),
    .cnt   (timer)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_ALL_RED;
      serve_ew_q    <= 1'b0;
      from_walk_q   <= 1'b0;
      ped_pending_q <= 1'b0;
      ped_ack_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      serve_ew_q    <= serve_ew_d;
      from_walk_q   <= from_walk_d;
      ped_ack_q     <= bus.ped_req && !ped_pending_q;
      // A new press in the same cycle WALK starts outlives the clear: it is served next rotation.
      ped_pending_q <= bus.ped_req ||
                       (ped_pending_q && !enters(state_q, state_d, ST_WALK));
    end
  end

  always_comb begin
    state_d     = state_q;
    serve_ew_d  = serve_ew_q;
    from_walk_d = from_walk_q;
    case (state_q)
      ST_ALL_RED: begin
        if (timer == ALLRED_LAST) begin
          if (ped_pending_q && !from_walk_q) state_d = ST_WALK;
          else if (serve_ew_q)               state_d = ST_EW_G;
          else                               state_d = ST_NS_G;
        end
      end
      ST_NS_G: begin
        if (timer >= GREEN_LAST && (bus.car_ew || ped_pending_q)) state_d = ST_NS_Y;
      end
      ST_NS_Y: begin
        if (timer == YELLOW_LAST) begin
          state_d    = ST_ALL_RED;
          serve_ew_d = 1'b1;
        end
      end
      ST_EW_G: begin
        if (timer >= GREEN_LAST && (bus.car_ns || ped_pending_q)) state_d = ST_EW_Y;
      end
      ST_EW_Y: begin
        if (timer == YELLOW_LAST) begin
          state_d    = ST_ALL_RED;
          serve_ew_d = 1'b0;
        end
      end
      ST_WALK: begin
        if (timer == WALK_LAST) begin
          state_d     = ST_ALL_RED;
          from_walk_d = 1'b1;
        end
      end
      default: state_d = ST_ALL_RED;
    endcase
    if (enters(state_q, state_d, ST_NS_G) || enters(state_q, state_d, ST_EW_G)) from_walk_d = 1'b0;
  end

  assign bus.ns_green  = (state_q == ST_NS_G);
  assign bus.ns_yellow = (state_q == ST_NS_Y);
  assign bus.ns_red    = !(bus.ns_green || bus.ns_yellow);
  assign bus.ew_green  = (state_q == ST_EW_G);
  assign bus.ew_yellow = (state_q == ST_EW_Y);
  assign bus.ew_red    = !(bus.ew_green || bus.ew_yellow);
  assign bus.walk      = (state_q == ST_WALK);
  assign bus.ped_ack   = ped_ack_q;
  assign bus.state     = state_q;

endmodule
